// File: rtl/perceptron_tables.sv
// Perceptron predictor state: speculative/committed GHR, in-flight count, weight table, 3-cycle trainer.
// rd_weights 1-cycle latency; res_ready low while training; PERCEPTRON_THETA_TRAIN_EN adds |sum|<=THETA training.
module perceptron_tables #(
  parameter int HIST_LEN = 20,
  parameter int WEIGHT_W = 8,
  parameter int ROWS     = 256,
  parameter int FETCH_N  = 4,
  parameter int MAX_SPEC = 8,
  parameter int THETA    = 52,
  localparam int IDX_W   = $clog2(ROWS),
  localparam int NW      = $clog2(FETCH_N + 1),
  localparam int PW      = $clog2(MAX_SPEC + 1),
  localparam int SUM_W   = WEIGHT_W + $clog2(HIST_LEN + 1) + 1,
  localparam int ROW_W   = (HIST_LEN + 1) * WEIGHT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [NW-1:0]       pred_num,
  input  logic [FETCH_N-1:0]  pred_dirs,
  output logic                pred_ready,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic                res_mispredict,
  input  logic [IDX_W-1:0]    res_row,
  input  logic [SUM_W-1:0]    res_sum,
  output logic                res_ready,
  input  logic [IDX_W-1:0]    rd_row,
  output logic [ROW_W-1:0]    rd_weights,
  output logic [HIST_LEN-1:0] spec_ghr,
  output logic [PW-1:0]       pending
);

  localparam int CW = ((PW > NW) ? PW : NW) + 1;
  localparam logic [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] WMIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, UPDATE, WRITE} state_t;

  state_t              state_q;
  logic [ROW_W-1:0]    table_q [ROWS];
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    row_upd;
  logic [ROW_W-1:0]    rd_weights_q;
  logic [IDX_W-1:0]    tr_row_q;
  logic                tr_taken_q;
  logic [HIST_LEN-1:0] tr_hist_q;
  logic [HIST_LEN-1:0] spec_ghr_q, spec_ghr_d;
  logic [HIST_LEN-1:0] cghr_q, cghr_d;
  logic [PW-1:0]       pending_q, pending_d;

  logic [CW-1:0]       pend_plus;
  logic [CW-1:0]       pend_sum;
  logic [FETCH_N-1:0]  dirs_rev;
  logic [FETCH_N-1:0]  dirs_packed;
  logic                pred_acc;
  logic                res_acc;
  logic                train;
  logic [HIST_LEN:0]   agree;

  assign res_ready  = (state_q == IDLE);
  assign pend_plus  = CW'(pending_q) + CW'(pred_num);
  assign pred_ready = (pend_plus <= CW'(MAX_SPEC));
  assign pred_acc   = pred_valid && pred_ready;
  assign res_acc    = res_valid && res_ready;

  assign rd_weights = rd_weights_q;
  assign spec_ghr   = spec_ghr_q;
  assign pending    = pending_q;

`ifdef PERCEPTRON_THETA_TRAIN_EN
  logic [SUM_W-1:0] abs_sum;
  assign abs_sum = res_sum[SUM_W-1] ? (~res_sum + 1'b1) : res_sum;
  assign train   = res_mispredict || (abs_sum <= SUM_W'(THETA));
`else
  logic unused_sum;
  assign unused_sum = ^{res_sum, SUM_W'(THETA)};
  assign train      = res_mispredict;
`endif

  // Oldest direction must land at bit pred_num-1: reverse, then drop the unused low lanes.
  always_comb begin
    dirs_rev = '0;
    for (int j = 0; j < FETCH_N; j++) begin
      dirs_rev[j] = pred_dirs[FETCH_N-1-j];
    end
    dirs_packed = dirs_rev >> (NW'(FETCH_N) - pred_num);
  end

  always_comb begin
    spec_ghr_d = spec_ghr_q;
    cghr_d     = cghr_q;
    pending_d  = pending_q;
    pend_sum   = '0;
    if (res_acc) begin
      cghr_d = {cghr_q[HIST_LEN-2:0], res_taken};
    end
    if (res_acc && res_mispredict) begin
      spec_ghr_d = {cghr_q[HIST_LEN-2:0], res_taken};
      pending_d  = '0;
    end else begin
      if (pred_acc) begin
        spec_ghr_d = (spec_ghr_q << pred_num) | HIST_LEN'(dirs_packed);
      end
      pend_sum = CW'(pending_q) + (pred_acc ? CW'(pred_num) : CW'(0));
      if (res_acc && (pend_sum != '0)) begin
        pend_sum = pend_sum - 1'b1;
      end
      pending_d = PW'(pend_sum);
    end
  end

  // agree[i] set means weight i moves up; bit 0 is the bias.
  assign agree = {~(tr_hist_q ^ {HIST_LEN{tr_taken_q}}), tr_taken_q};

  always_comb begin
    logic [WEIGHT_W-1:0] w;
    w       = '0;
    row_upd = row_q;
    for (int i = 0; i <= HIST_LEN; i++) begin
      w = row_q[i*WEIGHT_W +: WEIGHT_W];
      if (agree[i]) begin
        if (w != WMAX) w = w + 1'b1;
      end else begin
        if (w != WMIN) w = w - 1'b1;
      end
      row_upd[i*WEIGHT_W +: WEIGHT_W] = w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      rd_weights_q <= '0;
      tr_row_q     <= '0;
      tr_taken_q   <= 1'b0;
      tr_hist_q    <= '0;
      spec_ghr_q   <= '0;
      cghr_q       <= '0;
      pending_q    <= '0;
      for (int r = 0; r < ROWS; r++) begin
        table_q[r] <= '0;
      end
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      cghr_q       <= cghr_d;
      pending_q    <= pending_d;
      rd_weights_q <= table_q[rd_row];
      case (state_q)
        IDLE: begin
          if (res_acc && train) begin
            tr_row_q   <= res_row;
            tr_taken_q <= res_taken;
            tr_hist_q  <= cghr_q;
            state_q    <= READ;
          end
        end
        READ: begin
          row_q   <= table_q[tr_row_q];
          state_q <= UPDATE;
        end
        UPDATE: begin
          row_q   <= row_upd;
          state_q <= WRITE;
        end
        WRITE: begin
          table_q[tr_row_q] <= row_q;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_tables.sv
// Directed bench for perceptron_tables: history/pending bookkeeping, training, saturation, reset abort.
module tb_perceptron_tables;

  logic         clk = 1'b0;
  logic         rst;
  logic         pred_valid;
  logic [2:0]   pred_num;
  logic [3:0]   pred_dirs;
  logic         pred_ready;
  logic         res_valid;
  logic         res_taken;
  logic         res_mispredict;
  logic [7:0]   res_row;
  logic [13:0]  res_sum;
  logic         res_ready;
  logic [7:0]   rd_row;
  logic [167:0] rd_weights;
  logic [19:0]  spec_ghr;
  logic [3:0]   pending;

  int n_tests = 0;
  int n_fail  = 0;
  int ew [21];

  perceptron_tables dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_num(pred_num), .pred_dirs(pred_dirs), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_row(res_row), .res_sum(res_sum), .res_ready(res_ready),
    .rd_row(rd_row), .rd_weights(rd_weights), .spec_ghr(spec_ghr), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [167:0] pack_ew();
    logic [167:0] v;
    int           t;
    v = '0;
    for (int i = 0; i < 21; i++) begin
      t = ew[i];
      v[i*8 +: 8] = t[7:0];
    end
    return v;
  endfunction

  // Expected row after one training with outcome t and captured history h.
  task automatic set_one_train(input bit t, input logic [19:0] h);
    ew[0] = t ? 1 : -1;
    for (int i = 1; i < 21; i++) ew[i] = (t == h[i-1]) ? 1 : -1;
  endtask

  // Expected row after 130 same-outcome mispredicts starting from a history of all opposite bits.
  task automatic set_sat(input bit t);
    ew[0] = t ? 127 : -128;
    for (int i = 1; i < 21; i++) ew[i] = (130 - 2*i > 127) ? 127 : 130 - 2*i;
  endtask

  task automatic resolve_train(input bit t, input logic [7:0] row);
    res_valid = 1'b1; res_taken = t; res_mispredict = 1'b1; res_row = row;
    step();
    res_valid = 1'b0; res_mispredict = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    rst = 1'b0;
    pred_valid = 1'b0; pred_num = '0; pred_dirs = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0; res_row = '0; res_sum = '0;
    rd_row = 8'd5;
    step(); step();
    chk("reset_spec_ghr", spec_ghr, 20'h0);
    chk("reset_pending", pending, 4'd0);
    chk("reset_res_ready", res_ready, 1'b1);
    chk("reset_rd_weights", rd_weights, 168'h0);
    rst = 1'b1;
    step();

    // Row 5 taken mispredict from zero history; read during WRITE sees old contents.
    res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b1; res_row = 8'd5;
    step();
    res_valid = 1'b0; res_mispredict = 1'b0;
    chk("mp_spec_ghr", spec_ghr, 20'h1);
    chk("train_busy_read", res_ready, 1'b0);
    step();
    chk("train_busy_update", res_ready, 1'b0);
    step();
    chk("train_busy_write", res_ready, 1'b0);
    step();
    chk("read_during_write", rd_weights, 168'h0);
    chk("train_done_ready", res_ready, 1'b1);
    step();
    set_one_train(1'b1, 20'h0);
    chk("row5_trained", rd_weights, pack_ew());

    // Reset asserted while the FSM is in UPDATE.
    res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b1; res_row = 8'd5;
    step();
    res_valid = 1'b0; res_mispredict = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_spec_ghr", spec_ghr, 20'h0);
    chk("midrst_pending", pending, 4'd0);
    chk("midrst_res_ready", res_ready, 1'b1);
    chk("midrst_rd_weights", rd_weights, 168'h0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_row5_cleared", rd_weights, 168'h0);

    // Prediction groups up to the in-flight limit.
    pred_valid = 1'b1; pred_num = 3'd3; pred_dirs = 4'b0101;
    #1;
    chk("pred3_ready", pred_ready, 1'b1);
    step();
    chk("pred3_spec_ghr", spec_ghr, 20'h5);
    chk("pred3_pending", pending, 4'd3);
    pred_num = 3'd4; pred_dirs = 4'b0001;
    #1;
    chk("pred4_ready", pred_ready, 1'b1);
    step();
    chk("pred4_spec_ghr", spec_ghr, 20'h58);
    chk("pred4_pending", pending, 4'd7);
    pred_num = 3'd2; pred_dirs = 4'b0011;
    #1;
    chk("pred2_full_ready", pred_ready, 1'b0);
    step();
    pred_valid = 1'b0;
    chk("pred2_full_pending", pending, 4'd7);
    chk("pred2_full_spec_ghr", spec_ghr, 20'h58);

    // Two correct taken resolves: committed history 0x3, pending 5, no training.
    res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b0; res_row = 8'd1;
    step(); step();
    res_valid = 1'b0;
    chk("correct_pending", pending, 4'd5);
    chk("correct_res_ready", res_ready, 1'b1);
    chk("correct_spec_ghr", spec_ghr, 20'h58);

    // Mispredict with a simultaneous predict: flush wins.
    res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b1; res_row = 8'd7;
    pred_valid = 1'b1; pred_num = 3'd2; pred_dirs = 4'b0011;
    #1;
    chk("flush_pred_ready", pred_ready, 1'b1);
    step();
    res_valid = 1'b0; res_mispredict = 1'b0; pred_valid = 1'b0;
    chk("flush_spec_ghr", spec_ghr, 20'h7);
    chk("flush_pending", pending, 4'd0);
    chk("flush_busy1", res_ready, 1'b0);
    pred_valid = 1'b1; pred_num = 3'd1; pred_dirs = 4'b0001;
    #1;
    chk("pred_during_train_ready", pred_ready, 1'b1);
    step();
    pred_valid = 1'b0;
    chk("pred_during_train_ghr", spec_ghr, 20'hF);
    chk("pred_during_train_pending", pending, 4'd1);
    chk("flush_busy2", res_ready, 1'b0);
    step();
    chk("flush_busy3", res_ready, 1'b0);
    step();
    chk("flush_ready_again", res_ready, 1'b1);
    rd_row = 8'd7;
    step();
    set_one_train(1'b1, 20'h3);
    chk("row7_trained", rd_weights, pack_ew());

    // Saturation both ways, starting from a clean history.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int k = 0; k < 130; k++) resolve_train(1'b1, 8'd9);
    for (int k = 0; k < 130; k++) resolve_train(1'b0, 8'd10);
    rd_row = 8'd9;
    step();
    set_sat(1'b1);
    chk("row9_saturate_hi", rd_weights, pack_ew());
    rd_row = 8'd10;
    step();
    set_sat(1'b0);
    chk("row10_saturate_lo", rd_weights, pack_ew());

    // Correct prediction with a small sum on row 3.
    res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b0; res_row = 8'd3; res_sum = 14'd10;
    step();
    res_valid = 1'b0;
`ifdef PERCEPTRON_THETA_TRAIN_EN
    chk("theta_res_ready", res_ready, 1'b0);
`else
    chk("theta_res_ready", res_ready, 1'b1);
`endif
    step(); step(); step();
    rd_row = 8'd3;
    step();
`ifdef PERCEPTRON_THETA_TRAIN_EN
    set_one_train(1'b1, 20'h0);
    chk("theta_row3", rd_weights, pack_ew());
`else
    chk("theta_row3", rd_weights, 168'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
